twi_line_filter: RTL and testbench

Front-end conditioner for the TWI slave, sitting between the raw SCL/SDA pads and the TWI slave's `scl`/`sdaIn` inputs. It synchronises both lines into the system clock domain and glitch-filters them, producing clean levels plus single-cycle event strobes for SCL edges, START and STOP. It also tracks bus-busy state and flags a stuck-low SCL timeout.

---
 rtl/twi_line_filter.sv | 211 +++++++++++++++++++++
 tb/tb_twi_line_filter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twi_line_filter.sv
// twi_line_filter
// Conditions the raw TWI SCL/SDA pad levels for the TWI slave: two-flop
// synchronisers, a per-line run-length glitch filter, registered event
// strobes (SCL edges, START, STOP), bus-busy tracking and a stuck-low SCL
// timeout.

module twi_line_filter #(
  parameter int FILTER_CYCLES  = 4,      // samples at a new level before the filtered line moves, >= 1
  parameter int TIMEOUT_CYCLES = 50000   // filtered-SCL-low cycles while busy before a timeout, >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sclRaw,
  input  logic sdaRaw,
  output logic scl,
  output logic sdaIn,
  output logic sclRise,
  output logic sclFall,
  output logic startPulse,
  output logic stopPulse,
  output logic busBusy,
  output logic timeout
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int LINES = 2;
  localparam int L_SCL = 0;
  localparam int L_SDA = 1;

  // Filter counter only ever reaches FILTER_CYCLES-1; one spare bit keeps
  // FILTER_CYCLES=1 at a legal non-zero width.
  localparam int FW = $clog2(FILTER_CYCLES) + 1;
  // Timeout counter must be able to hold TIMEOUT_CYCLES itself (saturation value).
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [LINES-1:0] w_raw;
  logic [LINES-1:0] r_sync1;
  logic [LINES-1:0] r_sync2;      // sSync: synchronised line levels
  logic [LINES-1:0] r_filt;       // filtered line levels
  logic [FW-1:0]    r_cnt [LINES];

  logic             w_scl;
  logic             w_sda;
  logic             r_scl_q;
  logic             r_sda_q;

  logic             w_rise;
  logic             w_fall;
  logic             w_start;
  logic             w_stop;
  logic             w_to_run;
  logic             w_to_hit;
  logic             w_busy_nxt;
  logic [TW-1:0]    w_to_cnt_nxt;

  logic [TW-1:0]    r_to_cnt;
  logic             r_busy;
  logic             r_scl_rise;
  logic             r_scl_fall;
  logic             r_start;
  logic             r_stop;
  logic             r_timeout;

  assign w_raw = {sdaRaw, sclRaw};

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  // Two-flop synchroniser for both pads; idles high like a pulled-up bus.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value of its source, as real hardware does.
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter
  // ---------------------------------------------------------------------------
  // Per line: a filtered level only moves after FILTER_CYCLES consecutive
  // synchronised samples at the new level; any shorter run is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= '1;
      for (int i = 0; i < LINES; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == FILT_LAST) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i]  <= r_cnt[i] + FILT_ONE;
        end
      end
    end
  end

  assign w_scl = r_filt[L_SCL];
  assign w_sda = r_filt[L_SDA];

  // ---------------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------------
  // One-cycle-delayed copies of the filtered lines for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_q <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_q <= w_scl;
      r_sda_q <= w_sda;
    end
  end

  // Edge/START/STOP decode plus next-state of bus-busy and timeout counter.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    w_to_run     = 1'b0;
    w_to_hit     = 1'b0;
    w_busy_nxt   = r_busy;
    w_to_cnt_nxt = r_to_cnt;

    w_rise  = w_scl & ~r_scl_q;
    w_fall  = ~w_scl & r_scl_q;
    // SCL must be high and steady on both sides of the SDA edge, so an SDA
    // change coincident with an SCL change never counts as START or STOP.
    w_start = r_sda_q & ~w_sda & r_scl_q & w_scl;
    w_stop  = ~r_sda_q & w_sda & r_scl_q & w_scl;

    // Stuck-low watch: only meaningful while a transfer is in progress.
    w_to_run = r_busy & ~w_scl;
    w_to_hit = w_to_run & (r_to_cnt == TO_LAST);

    if (!w_to_run || w_to_hit) begin
      w_to_cnt_nxt = '0;
    end else if (r_to_cnt != TO_MAX) begin
      w_to_cnt_nxt = r_to_cnt + TO_ONE;
    end

    // STOP wins over timeout, timeout wins over START.
    if (w_stop) begin
      w_busy_nxt = 1'b0;
    end else if (w_to_hit) begin
      w_busy_nxt = 1'b0;
    end else if (w_start) begin
      w_busy_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus state, timeout counter and strobes
  // ---------------------------------------------------------------------------
  // Registered strobes and bus state; all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt   <= '0;
      r_busy     <= 1'b0;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_to_cnt   <= w_to_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_scl_rise <= w_rise;
      r_scl_fall <= w_fall;
      r_start    <= w_start;
      r_stop     <= w_stop;
      r_timeout  <= w_to_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign scl        = w_scl;
  assign sdaIn      = w_sda;
  assign sclRise    = r_scl_rise;
  assign sclFall    = r_scl_fall;
  assign startPulse = r_start;
  assign stopPulse  = r_stop;
  assign busBusy    = r_busy;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_twi_line_filter.sv
// tb_twi_line_filter
// Directed bench for twi_line_filter with FILTER_CYCLES=4, TIMEOUT_CYCLES=100.
// Inputs change 1 ns after a rising edge, so "edge 1" is the next rising edge;
// outputs are sampled 1 ns after each rising edge.

module tb_twi_line_filter;

  logic clk;
  logic rst;
  logic sclRaw;
  logic sdaRaw;
  logic scl;
  logic sdaIn;
  logic sclRise;
  logic sclFall;
  logic startPulse;
  logic stopPulse;
  logic busBusy;
  logic timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Running strobe counts, sampled mid-cycle.
  int n_rise  = 0;
  int n_fall  = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_to    = 0;

  int b_rise, b_fall, b_start, b_stop, b_to;

  twi_line_filter #(
    .FILTER_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclRaw     (sclRaw),
    .sdaRaw     (sdaRaw),
    .scl        (scl),
    .sdaIn      (sdaIn),
    .sclRise    (sclRise),
    .sclFall    (sclFall),
    .startPulse (startPulse),
    .stopPulse  (stopPulse),
    .busBusy    (busBusy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sclRise === 1'b1)    n_rise++;
    if (sclFall === 1'b1)    n_fall++;
    if (startPulse === 1'b1) n_start++;
    if (stopPulse === 1'b1)  n_stop++;
    if (timeout === 1'b1)    n_to++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_rise  = n_rise;
    b_fall  = n_fall;
    b_start = n_start;
    b_stop  = n_stop;
    b_to    = n_to;
  endtask

  // One full SCL clock: low, change SDA mid-low, high. 8 cycles per phase.
  task automatic scl_clock(input logic sda_bit);
    sclRaw = 1'b0;
    repeat (8) cyc();
    sdaRaw = sda_bit;
    repeat (8) cyc();
    sclRaw = 1'b1;
    repeat (8) cyc();
  endtask

  // Watchdog: the directed sequence is a few thousand cycles at most.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got 1 expected 0");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] data;
    int         e_fall;
    int         e_to;
    logic       busy_at_to;
    logic       busy_before_to;
    logic       prev_busy;

    rst    = 1'b1;
    sclRaw = 1'b1;
    sdaRaw = 1'b1;

    // ---- Idle after reset ------------------------------------------------
    repeat (3) cyc();
    check("rst_scl", scl, 1);
    check("rst_sda", sdaIn, 1);
    check("rst_busy", busBusy, 0);
    check("rst_strobes", {sclRise, sclFall, startPulse, stopPulse, timeout}, 0);
    rst = 1'b0;
    snap();
    repeat (50) cyc();
    check("idle_scl", scl, 1);
    check("idle_sda", sdaIn, 1);
    check("idle_busy", busBusy, 0);
    check("idle_strobe_cnt", (n_rise - b_rise) + (n_fall - b_fall) + (n_start - b_start)
                             + (n_stop - b_stop) + (n_to - b_to), 0);

    // ---- Glitch rejection: 3-cycle SCL low pulse -------------------------
    snap();
    sclRaw = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      check($sformatf("glitch3_scl_e%0d", e), scl, 1);
      if (e == 3) sclRaw = 1'b1;
    end
    check("glitch3_strobes", (n_rise - b_rise) + (n_fall - b_fall), 0);

    // ---- 4-cycle SCL low pulse passes ------------------------------------
    snap();
    sclRaw = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      cyc();
      check($sformatf("pulse4_scl_e%0d", e), scl, (e >= 6 && e <= 9) ? 0 : 1);
      check($sformatf("pulse4_fall_e%0d", e), sclFall, (e == 7) ? 1 : 0);
      check($sformatf("pulse4_rise_e%0d", e), sclRise, (e == 11) ? 1 : 0);
      if (e == 4) sclRaw = 1'b1;
    end
    check("pulse4_nrise", n_rise - b_rise, 1);
    check("pulse4_nfall", n_fall - b_fall, 1);
    check("pulse4_nstartstop", (n_start - b_start) + (n_stop - b_stop), 0);
    check("pulse4_busy", busBusy, 0);

    // ---- START ------------------------------------------------------------
    snap();
    sdaRaw = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      check($sformatf("start_sda_e%0d", e), sdaIn, (e >= 6) ? 0 : 1);
      check($sformatf("start_pulse_e%0d", e), startPulse, (e == 7) ? 1 : 0);
      check($sformatf("start_busy_e%0d", e), busBusy, (e >= 7) ? 1 : 0);
    end
    check("start_count", n_start - b_start, 1);

    // ---- Transfer: 9 SCL clocks, then STOP --------------------------------
    snap();
    data = 9'b101100100;
    for (int i = 8; i >= 0; i--) scl_clock(data[i]);
    check("xfer_nrise", n_rise - b_rise, 9);
    check("xfer_nfall", n_fall - b_fall, 9);
    check("xfer_nstart", n_start - b_start, 0);
    check("xfer_nstop", n_stop - b_stop, 0);
    check("xfer_busy", busBusy, 1);
    check("xfer_sda", sdaIn, 0);

    sdaRaw = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      check($sformatf("stop_pulse_e%0d", e), stopPulse, (e == 7) ? 1 : 0);
      check($sformatf("stop_busy_e%0d", e), busBusy, (e < 7) ? 1 : 0);
    end
    check("stop_count", n_stop - b_stop, 1);
    check("stop_nrise", n_rise - b_rise, 9);

    // ---- Repeated START ----------------------------------------------------
    sdaRaw = 1'b0;
    repeat (9) cyc();
    check("rs_first_busy", busBusy, 1);
    scl_clock(1'b1);
    check("rs_mid_busy", busBusy, 1);
    snap();
    sdaRaw = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      check($sformatf("rs_pulse_e%0d", e), startPulse, (e == 7) ? 1 : 0);
      check($sformatf("rs_busy_e%0d", e), busBusy, 1);
    end
    check("rs_count", n_start - b_start, 1);
    sdaRaw = 1'b1;
    repeat (9) cyc();
    check("rs_stop_busy", busBusy, 0);

    // ---- Simultaneous fall / rise while idle ---------------------------------
    snap();
    sclRaw = 1'b0;
    sdaRaw = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      check($sformatf("simf_fall_e%0d", e), sclFall, (e == 7) ? 1 : 0);
      check($sformatf("simf_start_e%0d", e), startPulse, 0);
      check($sformatf("simf_busy_e%0d", e), busBusy, 0);
    end
    sclRaw = 1'b1;
    sdaRaw = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      check($sformatf("simr_rise_e%0d", e), sclRise, (e == 7) ? 1 : 0);
      check($sformatf("simr_stop_e%0d", e), stopPulse, 0);
    end
    check("sim_nstartstop", (n_start - b_start) + (n_stop - b_stop), 0);

    // ---- Timeout ---------------------------------------------------------------
    sdaRaw = 1'b0;
    repeat (9) cyc();
    check("to_start_busy", busBusy, 1);
    snap();
    sclRaw         = 1'b0;
    e_fall         = -1;
    e_to           = -1;
    busy_at_to     = 1'b1;
    busy_before_to = 1'b0;
    prev_busy      = busBusy;
    for (int e = 1; e <= 200; e++) begin
      cyc();
      if (e_fall < 0 && scl == 1'b0) e_fall = e;
      if (e_to < 0 && timeout == 1'b1) begin
        e_to           = e;
        busy_at_to     = busBusy;
        busy_before_to = prev_busy;
      end
      prev_busy = busBusy;
    end
    check("to_fall_edge", e_fall, 6);
    check("to_seen", (e_to > 0) ? 1 : 0, 1);
    check("to_delay", e_to - e_fall, 100);
    check("to_busy_before", busy_before_to, 1);
    check("to_busy_at", busy_at_to, 0);
    repeat (150) cyc();
    check("to_once", n_to - b_to, 1);
    check("to_busy_after", busBusy, 0);

    // STOP while idle still pulses; then a fresh START.
    sclRaw = 1'b1;
    repeat (9) cyc();
    snap();
    sdaRaw = 1'b1;
    repeat (9) cyc();
    check("idle_stop_pulse", n_stop - b_stop, 1);
    check("idle_stop_busy", busBusy, 0);
    sdaRaw = 1'b0;
    repeat (9) cyc();
    check("to2_start_busy", busBusy, 1);

    // Reset in the middle of a timeout count.
    sclRaw = 1'b0;
    repeat (50) cyc();
    rst = 1'b1;
    cyc();
    check("midrst_busy", busBusy, 0);
    check("midrst_scl", scl, 1);
    check("midrst_sda", sdaIn, 1);
    check("midrst_strobes", {sclRise, sclFall, startPulse, stopPulse, timeout}, 0);
    cyc();
    check("midrst_strobes2", {sclRise, sclFall, startPulse, stopPulse, timeout}, 0);
    rst = 1'b0;
    snap();
    repeat (150) cyc();
    check("postrst_nstart", n_start - b_start, 0);
    check("postrst_nstop", n_stop - b_stop, 0);
    check("postrst_nto", n_to - b_to, 0);
    check("postrst_nfall", n_fall - b_fall, 1);
    check("postrst_busy", busBusy, 0);
    check("postrst_scl", scl, 0);
    check("postrst_sda", sdaIn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
